// File: rtl/matrix_dma_pkg.sv
// Shared definitions for the matrix accelerator DMA responder:
// FSM state encoding, error code values and the default poison word
// returned on failed reads.
package matrix_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_BUS     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/matrix_dma_responder_if.sv
// Accelerator DMA word-request port.
//   dma_req   level request, held while transfers remain
//   dma_addr  byte address of the current word
//   dma_we    1 = write, 0 = read
//   dma_wdata write data
//   dma_ack   one-cycle completion pulse
//   dma_rdata read data, valid while dma_ack=1
// master: accelerator side, slave: responder side.
interface matrix_dma_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  dma_req;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic                  dma_we;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_ack;
    logic [DATA_WIDTH-1:0] dma_rdata;

    modport master (
        output dma_req, dma_addr, dma_we, dma_wdata,
        input  dma_ack, dma_rdata
    );

    modport slave (
        input  dma_req, dma_addr, dma_we, dma_wdata,
        output dma_ack, dma_rdata
    );
endinterface

// File: rtl/matrix_dma_responder.sv
// Memory-side responder for the matrix accelerator DMA port. Each word
// request becomes one single-beat Wishbone cycle; misaligned addresses,
// bus errors and timeouts are reported but always acked so the
// accelerator never stalls.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   dma               accelerator request port (slave modport)
//   wbm_*             Wishbone master, single beat, sel fixed 4'hF
//   err_clr           clears sticky error status
//   err_o/err_code_o/err_addr_o  first-error status
//   busy_o            FSM not idle
//   rd_count_o/wr_count_o        completed transfer counters (wrap)
// DATA_WIDTH must be 32 because byte selects are fixed at 4'hF.
module matrix_dma_responder
    import matrix_dma_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    matrix_dma_responder_if.slave  dma,
    output logic [ADDR_WIDTH-1:0]  wbm_adr_o,
    output logic [DATA_WIDTH-1:0]  wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]  wbm_dat_i,
    output logic                   wbm_we_o,
    output logic [3:0]             wbm_sel_o,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    input  logic                   wbm_ack_i,
    input  logic                   wbm_err_i,
    input  logic                   err_clr,
    output logic                   err_o,
    output logic [1:0]             err_code_o,
    output logic [ADDR_WIDTH-1:0]  err_addr_o,
    output logic                   busy_o,
    output logic [15:0]            rd_count_o,
    output logic [15:0]            wr_count_o
);

    // Abort when the count of already-elapsed BUS cycles reaches this value
    // in the current BUS cycle, i.e. after exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [15:0]           tmo_q;
    logic                  xfer_we_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  start;
    logic                  bus_done;
    logic                  tmo_inc;
    logic                  fail;
    logic [1:0]            fail_code;
    logic [ADDR_WIDTH-1:0] fail_addr;

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        bus_done  = 1'b0;
        tmo_inc   = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;
        fail_addr = '0;
        case (state_q)
            ST_IDLE: begin
                if (dma.dma_req) begin
                    if (dma.dma_addr[1:0] == 2'b00) begin
                        start   = 1'b1;
                        state_d = ST_BUS;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_ALIGN;
                        fail_addr = dma.dma_addr;
                        state_d   = ST_ACK;
                    end
                end
            end
            ST_BUS: begin
                // err wins over a simultaneous ack
                if (wbm_err_i) begin
                    fail      = 1'b1;
                    fail_code = ERR_BUS;
                    fail_addr = wbm_adr_o;
                    state_d   = ST_ACK;
                end else if (wbm_ack_i) begin
                    bus_done = 1'b1;
                    state_d  = ST_ACK;
                end else if (tmo_q == TMO_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                    fail_addr = wbm_adr_o;
                    state_d   = ST_ACK;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            xfer_we_q  <= 1'b0;
            rdata_q    <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            err_addr_o <= '0;
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else begin
            state_q <= state_d;

            // Direction is remembered for every accepted request, including
            // misaligned ones that never reach the bus, so the counters see it.
            if (state_q == ST_IDLE && dma.dma_req)
                xfer_we_q <= dma.dma_we;

            if (start) begin
                wbm_adr_o <= dma.dma_addr;
                wbm_dat_o <= dma.dma_wdata;
                wbm_we_o  <= dma.dma_we;
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                tmo_q     <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + 16'd1;
            end

            if (state_q == ST_BUS && state_d != ST_BUS) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
            end

            if (fail)
                rdata_q <= ERR_DATA;
            else if (bus_done && !wbm_we_o)
                rdata_q <= wbm_dat_i;

            if (state_q == ST_ACK) begin
                if (xfer_we_q) wr_count_o <= wr_count_o + 16'd1;
                else           rd_count_o <= rd_count_o + 16'd1;
            end

            // First error sticks; a new error in the clear cycle is kept.
            if (fail && (!err_o || err_clr)) begin
                err_o      <= 1'b1;
                err_code_o <= fail_code;
                err_addr_o <= fail_addr;
            end else if (err_clr) begin
                err_o      <= 1'b0;
                err_code_o <= ERR_NONE;
                err_addr_o <= '0;
            end
        end
    end

    assign wbm_sel_o     = wbm_cyc_o ? 4'hF : 4'h0;
    assign dma.dma_ack   = (state_q == ST_ACK);
    assign dma.dma_rdata = rdata_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
